// File: rtl/nib_track_loader.sv
// nib_track_loader: streams each drive's current NIB track between SD sectors and its track RAM slot,
// writing a dirty track back before the next track is loaded.
module nib_track_loader #(
    parameter int DRIVES   = 2,
    parameter int SECS     = 13,
    parameter int TRK_W    = 6,
    parameter bit WAIT_ALL = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [DRIVES*TRK_W-1:0] track,
    input  logic [DRIVES-1:0]       img_mounted,
    input  logic [DRIVES-1:0]       img_present,
    input  logic [DRIVES-1:0]       dirty_set,
    output logic [31:0]             sd_lba,
    output logic [DRIVES-1:0]       sd_rd,
    output logic [DRIVES-1:0]       sd_wr,
    input  logic [DRIVES-1:0]       sd_ack,
    output logic [1:0]              buf_drive,
    output logic [3:0]              buf_sec,
    output logic                    cpu_wait,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, FLUSH, SWITCH, LOAD} state_t;
    state_t state, state_n;
    logic [DRIVES-1:0] valid, dirty, mount_seen, mfall, need, sel, pick_oh;
    logic [TRK_W-1:0]  cur_trk [DRIVES];
    logic [TRK_W-1:0]  pick_cur, pick_trk, trk_bd;
    logic [1:0]        pick;
    logic ack_q, abt, ack_now, rise, fall, xfer, halt, req, end_x, found, pick_flush;
    logic load_done, flush_done;

    function automatic logic [31:0] lba_of(input logic [TRK_W-1:0] t);
        return 32'(SECS) * 32'(t);
    endfunction

    assign mfall = mount_seen & ~img_mounted;
    assign req   = |{sd_rd, sd_wr};

    always_comb begin
        sel = '0;
        need = '0;
        pick_oh = '0;
        pick = '0;
        found = 1'b0;
        pick_flush = 1'b0;
        pick_cur = '0;
        pick_trk = '0;
        trk_bd = '0;
        // descending scan so the lowest-index requesting drive wins
        for (int i = DRIVES - 1; i >= 0; i--) begin
            sel[i] = 2'(i) == buf_drive;
            need[i] = img_present[i] & (~valid[i] | (cur_trk[i] != track[i*TRK_W +: TRK_W]));
            if (sel[i]) trk_bd = track[i*TRK_W +: TRK_W];
            if (need[i]) begin
                found = 1'b1;
                pick_oh = '0;
                pick_oh[i] = 1'b1;
                pick = 2'(i);
                pick_flush = valid[i] & dirty[i];
                pick_cur = cur_trk[i];
                pick_trk = track[i*TRK_W +: TRK_W];
            end
        end
        ack_now = |(sd_ack & sel);
        rise = ack_now & ~ack_q;
        fall = ~ack_now & ack_q;
        xfer = (state == FLUSH) || (state == LOAD);
        halt = abt | (|(mfall & sel));
        // an aborted phase ends once no sector is in flight
        end_x = xfer & ((fall & (~req | halt)) | (halt & ~ack_now & ~ack_q));
        load_done = end_x & ~halt & (state == LOAD);
        flush_done = end_x & ~halt & (state == FLUSH);
        state_n = state;
        if (state == IDLE) state_n = found ? (pick_flush ? FLUSH : LOAD) : IDLE;
        else if (state == SWITCH) state_n = halt ? IDLE : LOAD;
        else if (end_x) state_n = (halt || state == LOAD) ? IDLE : SWITCH;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
            sd_lba <= '0;
            sd_rd <= '0;
            sd_wr <= '0;
            buf_drive <= '0;
            buf_sec <= '0;
            cpu_wait <= 1'b0;
            busy <= 1'b0;
            valid <= '0;
            dirty <= '0;
            mount_seen <= '0;
            ack_q <= 1'b0;
            abt <= 1'b0;
            for (int i = 0; i < DRIVES; i++) cur_trk[i] <= '0;
        end else begin
            state <= state_n;
            ack_q <= ack_now;
            mount_seen <= img_mounted;
            valid <= (valid | (load_done ? sel : '0)) & ~mfall;
            dirty <= (dirty | (dirty_set & valid & ~((state != IDLE) ? sel : '0)))
                     & ~(flush_done ? sel : '0) & ~mfall;
            if (state == IDLE) begin
                abt <= 1'b0;
                if (found) begin
                    buf_drive <= pick;
                    buf_sec <= '0;
                    busy <= 1'b1;
                    cpu_wait <= 1'b1;
                    sd_lba <= lba_of(pick_flush ? pick_cur : pick_trk);
                    sd_wr <= pick_flush ? pick_oh : '0;
                    sd_rd <= pick_flush ? '0 : pick_oh;
                    for (int i = 0; i < DRIVES; i++)
                        if (pick_oh[i] && !pick_flush) cur_trk[i] <= pick_trk;
                end
            end else if (state == SWITCH) begin
                if (halt) begin
                    busy <= 1'b0;
                    cpu_wait <= 1'b0;
                end else begin
                    buf_sec <= '0;
                    sd_lba <= lba_of(trk_bd);
                    sd_rd <= sel;
                    for (int i = 0; i < DRIVES; i++)
                        if (sel[i]) cur_trk[i] <= trk_bd;
                end
            end else begin
                if (rise) sd_lba <= sd_lba + 32'd1;
                if ((rise && buf_sec == 4'(SECS - 1)) || halt) begin
                    sd_rd <= '0;
                    sd_wr <= '0;
                end
                if (halt) abt <= 1'b1;
                if (fall) buf_sec <= buf_sec + 4'd1;
                if (fall && !WAIT_ALL && state == LOAD && buf_sec == 4'd0) cpu_wait <= 1'b0;
                if (end_x && (halt || state == LOAD)) begin
                    busy <= 1'b0;
                    cpu_wait <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_nib_track_loader.sv
// tb_nib_track_loader: directed checks of track load, dirty flush, drive priority, remount,
// both cpu_wait policies and reset mid-transfer.
module tb_nib_track_loader;
    localparam int SECS = 13;
    logic clk = 1'b0, reset_n = 1'b0, u = 1'b0;
    logic [11:0] track0 = '0;
    logic [1:0]  mnt0 = '0, pres0 = '0, dset0 = '0, ack0 = '0, rd0, wr0, bd0;
    logic [31:0] lba0;
    logic [3:0]  bs0;
    logic        cw0, busy0;
    logic [5:0]  track1 = '0;
    logic        mnt1 = 1'b0, pres1 = 1'b0, dset1 = 1'b0, ack1 = 1'b0, rd1, wr1, cw1, busy1;
    logic [31:0] lba1;
    logic [1:0]  bd1;
    logic [3:0]  bs1;
    logic [31:0] o_lba;
    logic [1:0]  o_rd, o_wr, o_bd;
    logic [3:0]  o_bs;
    logic        o_cw, o_busy;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    nib_track_loader #(.DRIVES(2), .SECS(SECS), .TRK_W(6), .WAIT_ALL(0)) u_dut (
        .clk_sys(clk), .reset_n(reset_n), .track(track0), .img_mounted(mnt0),
        .img_present(pres0), .dirty_set(dset0), .sd_lba(lba0), .sd_rd(rd0), .sd_wr(wr0),
        .sd_ack(ack0), .buf_drive(bd0), .buf_sec(bs0), .cpu_wait(cw0), .busy(busy0)
    );

    nib_track_loader #(.DRIVES(1), .SECS(SECS), .TRK_W(6), .WAIT_ALL(1)) u_dut_all (
        .clk_sys(clk), .reset_n(reset_n), .track(track1), .img_mounted(mnt1),
        .img_present(pres1), .dirty_set(dset1), .sd_lba(lba1), .sd_rd(rd1), .sd_wr(wr1),
        .sd_ack(ack1), .buf_drive(bd1), .buf_sec(bs1), .cpu_wait(cw1), .busy(busy1)
    );

    assign o_lba  = u ? lba1 : lba0;
    assign o_rd   = u ? {1'b0, rd1} : rd0;
    assign o_wr   = u ? {1'b0, wr1} : wr0;
    assign o_bd   = u ? bd1 : bd0;
    assign o_bs   = u ? bs1 : bs0;
    assign o_cw   = u ? cw1 : cw0;
    assign o_busy = u ? busy1 : busy0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ack(input int d, input logic v);
        if (u) ack1 = v;
        else ack0[d] = v;
    endtask

    task automatic serve_sector(input int d, input bit wr, input logic [31:0] lba,
                                input logic [3:0] sec, input bit wb, input bit wa);
        logic [1:0] oh;
        oh = 2'(1 << d);
        chk("req_rd", o_rd, wr ? 2'b00 : oh);
        chk("req_wr", o_wr, wr ? oh : 2'b00);
        chk("lba", o_lba, lba);
        chk("sec", o_bs, sec);
        chk("drive", o_bd, d);
        chk("busy", o_busy, 1);
        chk("wait_pre", o_cw, wb);
        drive_ack(d, 1'b1);
        repeat (3) @(negedge clk);
        chk("lba_inc", o_lba, lba + 1);
        drive_ack(d, 1'b0);
        @(negedge clk);
        chk("sec_inc", o_bs, 4'(sec + 1));
        chk("wait_post", o_cw, wa);
    endtask

    task automatic serve_track(input int d, input bit wr, input logic [31:0] base);
        for (int s = 0; s < SECS; s++)
            serve_sector(d, wr, base + s, 4'(s), wr || (u ? 1'b1 : s == 0),
                         wr || (u && s != SECS - 1));
        chk("req_end", {o_rd, o_wr}, 0);
        chk("busy_end", o_busy, wr);
        chk("lba_end", o_lba, base + SECS);
        chk("wait_end", o_cw, wr);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lba", lba0, 0);
        chk("rst_req", {rd0, wr0}, 0);
        chk("rst_ctl", {bd0, bs0, cw0, busy0}, 0);
        chk("rst_all", {lba1, rd1, wr1, bd1, bs1, cw1, busy1}, 0);
        // plain load of drive 0, track 5
        reset_n = 1'b1;
        pres0 = 2'b01;
        track0[5:0] = 6'd5;
        @(negedge clk);
        serve_track(0, 1'b0, 32'd65);
        repeat (3) @(negedge clk);
        chk("idle_req", {rd0, wr0, busy0}, 0);
        // dirty write-back then reload of track 6
        dset0 = 2'b01;
        @(negedge clk);
        dset0 = 2'b00;
        track0[5:0] = 6'd6;
        @(negedge clk);
        serve_track(0, 1'b1, 32'd65);
        @(negedge clk);
        serve_track(0, 1'b0, 32'd78);
        // both drives change together: drive 0 first, then drive 1
        pres0 = 2'b11;
        track0 = {6'd2, 6'd7};
        @(negedge clk);
        serve_track(0, 1'b0, 32'd91);
        @(negedge clk);
        serve_track(1, 1'b0, 32'd26);
        // remount discards the dirty track: reload without write-back
        dset0 = 2'b01;
        @(negedge clk);
        dset0 = 2'b00;
        mnt0 = 2'b01;
        repeat (2) @(negedge clk);
        mnt0 = 2'b00;
        @(negedge clk);
        chk("mnt_idle", {rd0, wr0, busy0}, 0);
        @(negedge clk);
        serve_track(0, 1'b0, 32'd91);
        // whole-track cpu_wait policy on the single-drive instance
        u = 1'b1;
        pres1 = 1'b1;
        track1 = 6'd3;
        @(negedge clk);
        serve_track(0, 1'b0, 32'd39);
        track1 = 6'd4;
        @(negedge clk);
        serve_track(0, 1'b0, 32'd52);
        u = 1'b0;
        // reset during the fourth sector of a load
        track0[5:0] = 6'd8;
        @(negedge clk);
        for (int s = 0; s < 3; s++) serve_sector(0, 1'b0, 32'd104 + s, 4'(s), s == 0, 1'b0);
        chk("ack4_req", rd0, 2'b01);
        chk("ack4_sec", bs0, 3);
        drive_ack(0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_lba", lba0, 0);
        chk("mid_req", {rd0, wr0}, 0);
        chk("mid_ctl", {bd0, bs0, cw0, busy0}, 0);
        drive_ack(0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        serve_track(0, 1'b0, 32'd104);
        @(negedge clk);
        serve_track(1, 1'b0, 32'd26);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
